// File: rtl/vc_fifo.sv
`default_nettype none
// ============================================================================
// vc_fifo : per-virtual-channel input buffer feeding the VC mux, with
//           registered output, occupancy flags and a sticky error flag.
// Rev 1.0
// ============================================================================
module vc_fifo #(
  parameter int DATA_W    = 6,
  parameter int ADDR_W    = 2,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_AF    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] C_AE    = (ADDR_W+1)'(AE_THRESH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid_out;
  logic              r_error;

  logic w_pop_acc;
  logic w_push_acc;
  logic w_overflow;
  logic w_underflow;

  // Flags decode only the registered count, never the request inputs.
  assign full         = (r_count == C_DEPTH);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);

  // A pop on a full FIFO frees a slot, so the push in the same cycle is kept.
  assign w_pop_acc   = pop & ~empty;
  assign w_push_acc  = push & (~full | w_pop_acc);
  assign w_overflow  = push & full & ~pop;
  assign w_underflow = pop & empty;

  // Storage has no reset; only accepted pushes write it.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop_acc) begin
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
      end
      r_valid_out <= w_pop_acc;
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_overflow || w_underflow) begin
        r_error <= 1'b1;
      end
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign count     = r_count;
  assign error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_vc_fifo.sv
`default_nettype none
// ============================================================================
// tb_vc_fifo : directed and randomized checks of vc_fifo against a queue model.
// Rev 1.0
// ============================================================================
module tb_vc_fifo;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       push = 1'b0;
  logic [5:0] data_in = '0;
  logic       pop = 1'b0;
  logic [5:0] data_out;
  logic       valid_out;
  logic [2:0] count;
  logic       full, empty, almost_full, almost_empty, error;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of stored words plus the output register contents.
  logic [5:0] q[$];
  logic       m_valid = 1'b0;
  logic [5:0] m_data  = '0;
  logic       m_err   = 1'b0;

  vc_fifo dut (
    .clk(clk), .reset_L(reset_L), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .count(count), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] model_vec();
    int sz = q.size();
    return {m_valid, m_data, 3'(sz), m_err, sz == 4, sz == 0, sz >= 3, sz <= 1};
  endfunction

  // One clock: drive requests, advance the model, sample 1 time unit later.
  task automatic cycle(input logic p, input logic [5:0] d, input logic r);
    int   sz;
    logic pa;
    push = p; data_in = d; pop = r;
    @(posedge clk);
    sz = q.size();
    pa = r && (sz > 0);
    if ((p && sz == 4 && !r) || (r && sz == 0)) m_err = 1'b1;
    if (pa) begin
      m_data  = q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (p && (sz < 4 || pa)) q.push_back(d);
    #1;
    push = 1'b0; pop = 1'b0; data_in = 6'($urandom);
  endtask

  task automatic test_reset();
    logic [14:0] got;
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    got = {valid_out, data_out, count, error, full, empty, almost_full, almost_empty};
    checks++;
    if (got !== 15'b0_000000_000_0_0101) begin
      errors++;
      $display("FAIL reset_idle: got %h exp %h", got, 15'b0_000000_000_0_0101);
    end
  endtask

  task automatic test_fill_drain();
    logic [5:0]  words [4];
    logic [14:0] got;
    words = '{6'h34, 6'h25, 6'h21, 6'h2E};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, words[i], 1'b0);
      got = {valid_out, data_out, count, error, full, empty, almost_full, almost_empty};
      checks++;
      if (got !== model_vec() || count !== 3'(i + 1)) begin
        errors++;
        $display("FAIL fill_%0d: got %h exp %h", i, got, model_vec());
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 6'h00, 1'b1);
      got = {valid_out, data_out, count, error, full, empty, almost_full, almost_empty};
      checks++;
      if (got !== model_vec() || data_out !== words[i] || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL drain_%0d: data %h valid %b exp data %h valid 1", i, data_out, valid_out, words[i]);
      end
    end
    checks++;
    if (empty !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: empty %b error %b exp 1 0", empty, error);
    end
  endtask

  task automatic test_full_push_pop();
    logic [5:0] exp_out [5];
    exp_out = '{6'h34, 6'h25, 6'h21, 6'h2E, 6'h3A};
    cycle(1'b1, 6'h34, 1'b0); cycle(1'b1, 6'h25, 1'b0);
    cycle(1'b1, 6'h21, 1'b0); cycle(1'b1, 6'h2E, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(i == 0, 6'h3A, 1'b1);
      checks++;
      if (data_out !== exp_out[i] || valid_out !== 1'b1 ||
          (i == 0 && count !== 3'd4) || {count, error} !== {3'(q.size()), m_err}) begin
        errors++;
        $display("FAIL full_pushpop_%0d: data %h count %0d exp data %h count %0d",
                 i, data_out, count, exp_out[i], q.size());
      end
    end
  endtask

  task automatic test_overflow();
    logic [5:0] exp_out [4];
    exp_out = '{6'h11, 6'h22, 6'h33, 6'h04};
    for (int i = 0; i < 4; i++) cycle(1'b1, exp_out[i], 1'b0);
    cycle(1'b1, 6'h1F, 1'b0);
    checks++;
    if (count !== 3'd4 || error !== 1'b1 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow: count %0d error %b exp count 4 error 1", count, error);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 6'h00, 1'b1);
      checks++;
      if (data_out !== exp_out[i] || valid_out !== 1'b1 || error !== 1'b1) begin
        errors++;
        $display("FAIL overflow_drain_%0d: data %h error %b exp data %h error 1",
                 i, data_out, error, exp_out[i]);
      end
    end
  endtask

  task automatic test_underflow_push();
    cycle(1'b1, 6'h12, 1'b1);
    checks++;
    if (valid_out !== 1'b0 || count !== 3'd1 || error !== 1'b1) begin
      errors++;
      $display("FAIL underflow_push: valid %b count %0d error %b exp 0 1 1", valid_out, count, error);
    end
    cycle(1'b0, 6'h00, 1'b1);
    checks++;
    if (data_out !== 6'h12 || valid_out !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow_pop: data %h valid %b exp 12 1", data_out, valid_out);
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] got;
    cycle(1'b1, 6'h05, 1'b0); cycle(1'b1, 6'h06, 1'b1); cycle(1'b1, 6'h07, 1'b0);
    cycle(1'b1, 6'h08, 1'b0);
    #3;
    reset_L = 1'b0;
    #1;
    got = {valid_out, data_out, count, error, full, empty, almost_full, almost_empty};
    checks++;
    if (got !== 15'b0_000000_000_0_0101) begin
      errors++;
      $display("FAIL async_reset: got %h exp %h", got, 15'b0_000000_000_0_0101);
    end
    q.delete(); m_valid = 1'b0; m_data = '0; m_err = 1'b0;
    #1;
    reset_L = 1'b1;
    cycle(1'b1, 6'h1A, 1'b0);
    cycle(1'b0, 6'h00, 1'b1);
    checks++;
    if (data_out !== 6'h1A || valid_out !== 1'b1 || empty !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_after: data %h valid %b empty %b exp 1a 1 1", data_out, valid_out, empty);
    end
    cycle(1'b0, 6'h00, 1'b1);
    checks++;
    if (valid_out !== 1'b0 || error !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_stale: valid %b error %b exp 0 1", valid_out, error);
    end
  endtask

  task automatic test_random();
    logic [14:0] got;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 6'($urandom), 1'($urandom_range(0, 99) < 45));
      got = {valid_out, data_out, count, error, full, empty, almost_full, almost_empty};
      checks++;
      if (got !== model_vec()) begin
        errors++;
        $display("FAIL random_%0d: got %h exp %h", i, got, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_overflow();
    q.delete(); m_valid = 1'b0; m_data = '0; m_err = 1'b0;
    reset_L = 1'b0; #2; reset_L = 1'b1;
    test_underflow_push();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
